// File: rtl/tpu_host_sequencer.sv
// Host-side sequencer for the tt_um_tpu pin protocol: takes one 2x2 int8
// matmul job, shifts it onto ui_in/uio_in, waits the fixed TPU latency,
// collects the 8 result bytes from uo_out and offers them as four 16-bit words.
module tpu_host_sequencer #(
  parameter int LOAD_BYTES = 8,
  parameter int LAT        = 4,
  parameter int OUT_BYTES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_data,
  input  logic        cmd_transpose,
  input  logic        cmd_activation,
  output logic [7:0]  tpu_ui_in,
  output logic [7:0]  tpu_uio_in,
  input  logic [7:0]  tpu_uo_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPT,
    S_RESP
  } state_t;

  localparam logic [2:0] LOAD_LAST = 3'(LOAD_BYTES - 1);
  localparam logic [2:0] OUT_LAST  = 3'(OUT_BYTES - 1);
  // WAIT lasts LAT-1 cycles; with LAT==1 it is skipped entirely.
  localparam logic [7:0] LAT_LAST  = (LAT >= 2) ? 8'(LAT - 2) : 8'd0;
  localparam bit         LAT_SKIP  = (LAT == 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_lat, w_lat_nxt;
  logic [63:0] r_job, w_job_nxt;
  logic        r_trans, w_trans_nxt;
  logic        r_act, w_act_nxt;
  logic [7:0]  r_ui, w_ui_nxt;
  logic [7:0]  r_uio, w_uio_nxt;
  logic [63:0] r_rsp;

  // Next-state, counters, job latch and next values for the registered TPU pins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lat_nxt   = r_lat;
    w_job_nxt   = r_job;
    w_trans_nxt = r_trans;
    w_act_nxt   = r_act;
    w_ui_nxt    = 8'h00;
    w_uio_nxt   = 8'h00;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = S_LOAD;
          w_job_nxt   = cmd_data;
          w_trans_nxt = cmd_transpose;
          w_act_nxt   = cmd_activation;
        end
      end
      S_LOAD: begin
        if (r_cnt == LOAD_LAST) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = LAT_SKIP ? S_CAPT : S_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_WAIT: begin
        if (r_lat == LAT_LAST) begin
          w_lat_nxt   = 8'd0;
          w_state_nxt = S_CAPT;
        end else begin
          w_lat_nxt = r_lat + 8'd1;
        end
      end
      S_CAPT: begin
        if (r_cnt == OUT_LAST) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Pins are registered from the upcoming state so each LOAD cycle shows its own byte.
    case (w_state_nxt)
      S_LOAD: begin
        w_ui_nxt  = w_job_nxt[{w_cnt_nxt, 3'b000} +: 8];
        w_uio_nxt = {5'b00000, w_act_nxt, w_trans_nxt, 1'b1};
      end
      S_WAIT, S_CAPT: begin
        w_uio_nxt = {5'b00000, w_act_nxt, w_trans_nxt, 1'b0};
      end
      default: begin
        w_ui_nxt  = 8'h00;
        w_uio_nxt = 8'h00;
      end
    endcase
  end

  // State, counters, latched job and TPU pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_lat   <= 8'd0;
      r_job   <= 64'd0;
      r_trans <= 1'b0;
      r_act   <= 1'b0;
      r_ui    <= 8'h00;
      r_uio   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lat   <= w_lat_nxt;
      r_job   <= w_job_nxt;
      r_trans <= w_trans_nxt;
      r_act   <= w_act_nxt;
      r_ui    <= w_ui_nxt;
      r_uio   <= w_uio_nxt;
    end
  end

  // Result bytes land in order; the previous result persists until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp <= 64'd0;
    end else if (r_state == S_CAPT) begin
      r_rsp[{r_cnt, 3'b000} +: 8] <= tpu_uo_out;
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign rsp_data   = r_rsp;
  assign tpu_ui_in  = r_ui;
  assign tpu_uio_in = r_uio;

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Bench for tpu_host_sequencer: three instances (LAT = 4, 1, 255), each wired
// to a small behavioural TPU that multiplies W(2x2) by X(2x2) and streams the
// results back LAT cycles after the last load byte (transpose/activation ignored).
module tb_tpu_host_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid [3];
  logic        rsp_ready [3];
  logic [63:0] cmd_data;
  logic        cmd_transpose;
  logic        cmd_activation;
  logic        cmd_ready [3];
  logic        rsp_valid [3];
  logic        busy      [3];
  logic [7:0]  ui        [3];
  logic [7:0]  uio       [3];
  logic [63:0] rsp_data  [3];

  int total = 0;
  int bad   = 0;

  logic [7:0]  tr_ui  [32];
  logic [7:0]  tr_uio [32];
  int          lat_o;
  logic [63:0] rsp_o;

  localparam logic [63:0] D1   = 64'h0807060504030201;
  localparam logic [63:0] E1   = 64'h0032002B00160013;
  localparam logic [63:0] D2   = 64'h06FB807F8003FEFF;
  localparam logic [63:0] E2   = 64'hFB8003FD0074FF8B;

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mm(input logic [63:0] d);
    int w [4];
    int x [4];
    int c [4];
    logic [63:0] r;
    for (int i = 0; i < 4; i++) begin
      w[i] = int'($signed(d[8*i +: 8]));
      x[i] = int'($signed(d[32 + 8*i +: 8]));
    end
    c[0] = w[0] * x[0] + w[1] * x[2];
    c[1] = w[0] * x[1] + w[1] * x[3];
    c[2] = w[2] * x[0] + w[3] * x[2];
    c[3] = w[2] * x[1] + w[3] * x[3];
    for (int i = 0; i < 4; i++) r[16*i +: 16] = c[i][15:0];
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 255);
    logic [7:0]  m_uo;
    logic [7:0]  m_buf [8];
    int          m_idx;
    int          m_t;
    bit          m_run;
    logic [63:0] m_res;

    tpu_host_sequencer #(.LOAD_BYTES(8), .LAT(L), .OUT_BYTES(8)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid[g]),
      .cmd_ready      (cmd_ready[g]),
      .cmd_data       (cmd_data),
      .cmd_transpose  (cmd_transpose),
      .cmd_activation (cmd_activation),
      .tpu_ui_in      (ui[g]),
      .tpu_uio_in     (uio[g]),
      .tpu_uo_out     (m_uo),
      .rsp_valid      (rsp_valid[g]),
      .rsp_ready      (rsp_ready[g]),
      .rsp_data       (rsp_data[g]),
      .busy           (busy[g])
    );

    // Behavioural TPU: registered uo_out, first byte LAT cycles after the last load cycle.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_idx = 0;
        m_t   = 0;
        m_run = 0;
        m_uo <= 8'h00;
      end else begin
        if (uio[g][0]) begin
          m_buf[m_idx] = ui[g];
          m_idx++;
          if (m_idx == 8) begin
            m_idx = 0;
            m_res = ref_mm({m_buf[7], m_buf[6], m_buf[5], m_buf[4],
                            m_buf[3], m_buf[2], m_buf[1], m_buf[0]});
            m_run = 1;
            m_t   = 0;
          end
        end
        if (m_run) begin
          m_t++;
          if (m_t >= L && m_t < L + 8) begin
            m_uo <= m_res[8*(m_t - L) +: 8];
          end else begin
            m_uo <= 8'h00;
            if (m_t >= L + 8) m_run = 0;
          end
        end
      end
    end
  end

  // Offers one job on instance g, then records pins per cycle until rsp_valid.
  task automatic drive_job(input int g, input logic [63:0] d, input bit t, input bit a);
    int n;
    n = 0;
    lat_o = -1;
    @(negedge clk);
    cmd_data       = d;
    cmd_transpose  = t;
    cmd_activation = a;
    cmd_valid[g]   = 1'b1;
    while (!cmd_ready[g] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready[g]) begin
      cmd_valid[g] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid[g] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n < 32) begin
        tr_ui[n]  = ui[g];
        tr_uio[n] = uio[g];
      end
    end while (!rsp_valid[g] && n < 600);
    lat_o = rsp_valid[g] ? n : -1;
    rsp_o = rsp_data[g];
  endtask

  task automatic respond(input int g);
    @(negedge clk);
    rsp_ready[g] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[g] = 1'b0;
  endtask

  task automatic test_reset();
    int hits;
    @(negedge clk);
    total++;
    if (cmd_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b want 1 0 0", cmd_ready[0], rsp_valid[0], busy[0]);
    end
    total++;
    if (rsp_data[0] !== 64'd0 || ui[0] !== 8'h00 || uio[0] !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got rsp=%h ui=%h uio=%h want 0 0 0", rsp_data[0], ui[0], uio[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd_data = D1;
    cmd_valid[0] = 1'b1;
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (uio[0] !== 8'h01 || ui[0] !== 8'h03) begin
      bad++;
      $display("FAIL mid_load: got ui=%h uio=%h want 03 01", ui[0], uio[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (uio[0] !== 8'h00 || ui[0] !== 8'h00 || cmd_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_midjob: got ui=%h uio=%h rdy=%b vld=%b busy=%b want 00 00 1 0 0",
               ui[0], uio[0], cmd_ready[0], rsp_valid[0], busy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid[0] || busy[0]) hits++;
    end
    total++;
    if (hits !== 0) begin
      bad++;
      $display("FAIL no_rsp_after_reset: got %0d active cycles want 0", hits);
    end
  endtask

  task automatic test_basic();
    drive_job(0, D1, 1'b0, 1'b0);
    total++;
    if (lat_o !== 20) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 20", lat_o);
    end
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (tr_ui[k] !== 8'(k) || tr_uio[k] !== 8'h01) begin
        bad++;
        $display("FAIL load_byte%0d: got ui=%h uio=%h want %h 01", k - 1, tr_ui[k], tr_uio[k], 8'(k));
      end
    end
    for (int k = 9; k <= 20; k++) begin
      total++;
      if (tr_ui[k] !== 8'h00 || tr_uio[k] !== 8'h00) begin
        bad++;
        $display("FAIL idle_pins_c%0d: got ui=%h uio=%h want 00 00", k, tr_ui[k], tr_uio[k]);
      end
    end
    total++;
    if (rsp_o !== E1) begin
      bad++;
      $display("FAIL basic_result: got %h want %h", rsp_o, E1);
    end
    total++;
    if (busy[0] !== 1'b1 || cmd_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL resp_ctrl: got busy=%b rdy=%b want 1 0", busy[0], cmd_ready[0]);
    end
    respond(0);
    @(negedge clk);
    total++;
    if (rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1 || rsp_data[0] !== E1) begin
      bad++;
      $display("FAIL after_handshake: got vld=%b rdy=%b rsp=%h want 0 1 %h", rsp_valid[0], cmd_ready[0], rsp_data[0], E1);
    end
  endtask

  task automatic test_flags();
    drive_job(0, D1, 1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      logic [7:0] want;
      want = (k <= 8) ? 8'h07 : ((k <= 19) ? 8'h06 : 8'h00);
      total++;
      if (tr_uio[k] !== want) begin
        bad++;
        $display("FAIL flags_uio_c%0d: got %h want %h", k, tr_uio[k], want);
      end
    end
    total++;
    if (rsp_o !== E1) begin
      bad++;
      $display("FAIL flags_result: got %h want %h", rsp_o, E1);
    end
    respond(0);
  endtask

  task automatic test_backpressure();
    int stall_bad;
    int n;
    drive_job(0, D2, 1'b0, 1'b0);
    total++;
    if (lat_o !== 20 || rsp_o !== E2) begin
      bad++;
      $display("FAIL neg_result: got lat=%0d rsp=%h want 20 %h", lat_o, rsp_o, E2);
    end
    stall_bad = 0;
    repeat (50) begin
      @(negedge clk);
      cmd_valid[0]  = 1'b1;
      cmd_data      = {$urandom, $urandom};
      cmd_transpose = 1'($urandom);
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== E2 || cmd_ready[0] !== 1'b0 ||
          ui[0] !== 8'h00 || uio[0] !== 8'h00) stall_bad++;
    end
    total++;
    if (stall_bad !== 0) begin
      bad++;
      $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad);
    end
    cmd_data       = D1;
    cmd_transpose  = 1'b0;
    cmd_activation = 1'b0;
    rsp_ready[0]   = 1'b1;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_stall: got rdy=%b vld=%b busy=%b want 1 0 0", cmd_ready[0], rsp_valid[0], busy[0]);
    end
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[0] && n < 600);
    total++;
    if (n !== 20 || rsp_data[0] !== E1) begin
      bad++;
      $display("FAIL queued_job: got lat=%0d rsp=%h want 20 %h", n, rsp_data[0], E1);
    end
    respond(0);
  endtask

  task automatic test_lat();
    for (int g = 1; g <= 2; g++) begin
      int want;
      want = (g == 1) ? 17 : 271;
      drive_job(g, D2, 1'b0, 1'b0);
      total++;
      if (lat_o !== want) begin
        bad++;
        $display("FAIL lat_build%0d_latency: got %0d want %0d", g, lat_o, want);
      end
      total++;
      if (rsp_o !== E2) begin
        bad++;
        $display("FAIL lat_build%0d_result: got %h want %h", g, rsp_o, E2);
      end
      respond(g);
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 100; j++) begin
      logic [63:0] d;
      logic [63:0] e;
      d = {$urandom, $urandom};
      if (j % 4 == 0) d = d | 64'h8080808080808080;
      e = ref_mm(d);
      drive_job(0, d, 1'($urandom), 1'($urandom));
      total++;
      if (rsp_o !== e || lat_o !== 20) begin
        bad++;
        $display("FAIL b2b_job%0d: got rsp=%h lat=%0d want %h 20 (in %h)", j, rsp_o, lat_o, e, d);
      end
      respond(0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    cmd_data       = 64'd0;
    cmd_transpose  = 1'b0;
    cmd_activation = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_flags();
    test_backpressure();
    test_lat();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
